// File: rtl/contador_updown_param.sv
// -----------------------------------------------------------------------------
// contador_updown_param
//   Parametrised up/down binary counter with a modulo range of 0..MAX_VAL,
//   count enable, direction select, parallel load, and a wrap or saturate mode.
//   The terminal-count output lets instances cascade through tc -> en.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   MAX_VAL   highest count value; the count range is 0..MAX_VAL
//   SATURATE  0 = wrap at the range ends, 1 = hold at the range ends
//   RST_VAL   value loaded into q on reset (must be <= MAX_VAL)
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-low reset
//   en    in   1      count enable
//   up    in   1      direction: 1 = increment, 0 = decrement
//   load  in   1      parallel load strobe (ignores en and up)
//   din   in   WIDTH  parallel load value, clamped to MAX_VAL
//   q     out  WIDTH  current count (registered)
//   tc    out  1      terminal count (combinational): en & at range end
//   ovf   out  1      registered one-cycle pulse after a wrap/saturation hit
//
// Update priority at each rising edge: reset > load > count > hold.
// -----------------------------------------------------------------------------
module contador_updown_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             end_hit;

    // end_hit: q sits at the end of the range in the current count direction.
    always_comb begin
        end_hit = up ? (q_q == MAX_Q) : (q_q == '0);
        tc      = en & end_hit;
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (load) begin
            // Clamp so an out-of-range load can never reach q.
            q_d = (din > MAX_Q) ? MAX_Q : din;
        end else if (en) begin
            if (end_hit) begin
                // Wrap/saturation event; in saturate mode q stays pinned and
                // ovf keeps pulsing on every enabled edge.
                ovf_d = 1'b1;
                if (SATURATE == 0) begin
                    q_d = up ? '0 : MAX_Q;
                end
            end else begin
                q_d = up ? (q_q + 1'b1) : (q_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q   <= RST_Q;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule
